// File: rtl/oled_fb_pkg.sv
// Shared constants, fetch FSM encoding and pixel-format conversion for the OLED frame-buffer path.
package oled_fb_pkg;

    localparam int FRAC_W = 32'd8;
    localparam int STEP_X = (32'd320 << FRAC_W) / 32'd96;
    localparam int STEP_Y = (32'd240 << FRAC_W) / 32'd64;
    localparam int XY_W   = 32'd7;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } fb_state_e;

    // Buffer word {r5, g5, b6} to RGB565: green widened by MSB replication, blue truncated.
    function automatic logic [15:0] rgb_buf_to_565(input logic [15:0] pxl);
        return {pxl[15:11], pxl[10:6], pxl[10], pxl[5:1]};
    endfunction

endpackage

// File: rtl/oled_scale_dda.sv
// Nearest-neighbour raster stepper: walks the OLED raster and tracks the matching source pixel.
// With OLED_FB_READER_XY_CHECK_EN defined, exposes dx/dy and accepts a position reload.
module oled_scale_dda
    import oled_fb_pkg::*;
#(
    parameter int SRC_COLS = 32'd320,
    parameter int SRC_ROWS = 32'd240,
    parameter int DST_COLS = 32'd96,
    parameter int DST_ROWS = 32'd64,
    parameter int FRAC_P   = FRAC_W,
    parameter int STEP_X_P = STEP_X,
    parameter int STEP_Y_P = STEP_Y,
    parameter int SX_W     = $clog2(SRC_COLS),
    parameter int SY_W     = $clog2(SRC_ROWS)
) (
    input  logic            oclk,
    input  logic            rst,
    input  logic            advance,
    input  logic            restart,
`ifdef OLED_FB_READER_XY_CHECK_EN
    input  logic            load,
    input  logic [XY_W-1:0] load_dx,
    input  logic [XY_W-1:0] load_dy,
    output logic [XY_W-1:0] dx,
    output logic [XY_W-1:0] dy,
`endif
    output logic [SX_W-1:0] sx,
    output logic [SY_W-1:0] sy,
    output logic            last_pixel
);

    localparam int ACC_W = 32'd20;
    localparam int INT_W = ACC_W - FRAC_P;
    localparam logic [ACC_W-1:0] STEP_X_A = ACC_W'(STEP_X_P);
    localparam logic [ACC_W-1:0] STEP_Y_A = ACC_W'(STEP_Y_P);
    localparam logic [XY_W-1:0]  DX_LAST  = XY_W'(DST_COLS - 32'd1);
    localparam logic [XY_W-1:0]  DY_LAST  = XY_W'(DST_ROWS - 32'd1);
    localparam logic [XY_W-1:0]  XY_ONE   = XY_W'(32'd1);
    localparam logic [INT_W-1:0] SX_MAX   = INT_W'(SRC_COLS - 32'd1);
    localparam logic [INT_W-1:0] SY_MAX   = INT_W'(SRC_ROWS - 32'd1);

    logic [XY_W-1:0]  dx_r, dy_r;
    logic [ACC_W-1:0] sx_fp_r, sy_fp_r;
    logic [INT_W-1:0] sx_int_s, sy_int_s;

    // Raster position and fixed-point source accumulators; row end resets x and steps y.
    always_ff @(posedge oclk) begin
        if (rst || restart) begin
            dx_r    <= '0;
            dy_r    <= '0;
            sx_fp_r <= '0;
            sy_fp_r <= '0;
        end
`ifdef OLED_FB_READER_XY_CHECK_EN
        else if (load) begin
            dx_r    <= load_dx;
            dy_r    <= load_dy;
            sx_fp_r <= ACC_W'(load_dx) * STEP_X_A;
            sy_fp_r <= ACC_W'(load_dy) * STEP_Y_A;
        end
`endif
        else if (advance) begin
            if (dx_r == DX_LAST) begin
                dx_r    <= '0;
                sx_fp_r <= '0;
                if (dy_r == DY_LAST) begin
                    dy_r    <= '0;
                    sy_fp_r <= '0;
                end else begin
                    dy_r    <= dy_r + XY_ONE;
                    sy_fp_r <= sy_fp_r + STEP_Y_A;
                end
            end else begin
                dx_r    <= dx_r + XY_ONE;
                sx_fp_r <= sx_fp_r + STEP_X_A;
            end
        end
    end

    // Integer source coordinates, clamped so truncation drift can never leave the frame.
    always_comb begin
        sx_int_s = sx_fp_r[ACC_W-1:FRAC_P];
        sy_int_s = sy_fp_r[ACC_W-1:FRAC_P];
        if (sx_int_s > SX_MAX) begin
            sx = SX_MAX[SX_W-1:0];
        end else begin
            sx = sx_int_s[SX_W-1:0];
        end
        if (sy_int_s > SY_MAX) begin
            sy = SY_MAX[SY_W-1:0];
        end else begin
            sy = sy_int_s[SY_W-1:0];
        end
        last_pixel = (dx_r == DX_LAST) && (dy_r == DY_LAST);
    end

`ifdef OLED_FB_READER_XY_CHECK_EN
    assign dx = dx_r;
    assign dy = dy_r;
`endif

endmodule

// File: rtl/oled_fb_reader.sv
// Frame-buffer to OLED pixel source: prefetches the downscaled pixel and serves it on next_pixel.
// Optional OLED_FB_READER_XY_CHECK_EN adds x/y position checking with realignment and sticky xy_err.
module oled_fb_reader
    import oled_fb_pkg::*;
#(
    parameter int SRC_COLS = 32'd320,
    parameter int SRC_ROWS = 32'd240,
    parameter int DST_COLS = 32'd96,
    parameter int DST_ROWS = 32'd64,
    parameter int ADDR_W   = 32'd17,
    parameter int PXL_W    = 32'd16,
    parameter int RD_LAT   = 32'd1,
    parameter int FRAC_W   = 32'd8
) (
    input  logic              oclk,
    input  logic              rst,
    input  logic              next_pixel,
    input  logic              resync,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [PXL_W-1:0]  fb_pxl,
    output logic [15:0]       color,
    output logic              frame_done,
`ifdef OLED_FB_READER_XY_CHECK_EN
    input  logic [6:0]        x,
    input  logic [6:0]        y,
    output logic              xy_err,
`endif
    output logic              underrun
);

    localparam int SX_W = $clog2(SRC_COLS);
    localparam int SY_W = $clog2(SRC_ROWS);
    localparam logic [1:0]        RD_LAT_C   = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] SRC_COLS_A = ADDR_W'(SRC_COLS);

    fb_state_e         state_r, state_nx_s;
    logic [1:0]        lat_r;
    logic [PXL_W-1:0]  pend_r;
    logic [ADDR_W-1:0] fb_addr_r, addr_s;
    logic [15:0]       color_r;
    logic              frame_done_r, underrun_r;
    logic              strobe_s, issue_s, decr_s, capture_s, consume_s, underrun_ev_s;
    logic              xy_mismatch_s, last_pixel_s;
    logic [SX_W-1:0]   sx_s;
    logic [SY_W-1:0]   sy_s;

`ifdef OLED_FB_READER_XY_CHECK_EN
    localparam logic [XY_W-1:0] DX_LAST = XY_W'(DST_COLS - 32'd1);
    localparam logic [XY_W-1:0] DY_LAST = XY_W'(DST_ROWS - 32'd1);
    logic [XY_W-1:0] dx_s, dy_s, load_dx_s, load_dy_s;
    logic            xy_err_r;

    // Position check against oled_video; on mismatch realign to the pixel after (x, y).
    always_comb begin
        xy_mismatch_s = strobe_s && ((x != dx_s) || (y != dy_s));
        if (x == DX_LAST) begin
            load_dx_s = '0;
            if (y == DY_LAST) begin
                load_dy_s = '0;
            end else begin
                load_dy_s = y + XY_W'(32'd1);
            end
        end else begin
            load_dx_s = x + XY_W'(32'd1);
            load_dy_s = y;
        end
    end

    // Sticky position-error flag.
    always_ff @(posedge oclk) begin
        if (rst) begin
            xy_err_r <= 1'b0;
        end else if (xy_mismatch_s) begin
            xy_err_r <= 1'b1;
        end
    end

    assign xy_err = xy_err_r;
`else
    assign xy_mismatch_s = 1'b0;
`endif

    oled_scale_dda #(
        .SRC_COLS (SRC_COLS),
        .SRC_ROWS (SRC_ROWS),
        .DST_COLS (DST_COLS),
        .DST_ROWS (DST_ROWS),
        .FRAC_P   (FRAC_W),
        .STEP_X_P ((SRC_COLS << FRAC_W) / DST_COLS),
        .STEP_Y_P ((SRC_ROWS << FRAC_W) / DST_ROWS),
        .SX_W     (SX_W),
        .SY_W     (SY_W)
    ) u_dda (
        .oclk       (oclk),
        .rst        (rst),
        .advance    (strobe_s),
        .restart    (resync),
`ifdef OLED_FB_READER_XY_CHECK_EN
        .load       (xy_mismatch_s),
        .load_dx    (load_dx_s),
        .load_dy    (load_dy_s),
        .dx         (dx_s),
        .dy         (dy_s),
`endif
        .sx         (sx_s),
        .sy         (sy_s),
        .last_pixel (last_pixel_s)
    );

    // Fetch FSM state register.
    always_ff @(posedge oclk) begin
        if (rst) begin
            state_r <= ISSUE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Any strobe or resync restarts the fetch for the new raster position.
    always_comb begin
        state_nx_s = state_r;
        if (resync || next_pixel) begin
            state_nx_s = ISSUE;
        end else begin
            case (state_r)
                ISSUE:   state_nx_s = WAIT;
                WAIT:    state_nx_s = (lat_r == 2'd0) ? READY : WAIT;
                READY:   state_nx_s = READY;
                default: state_nx_s = ISSUE;
            endcase
        end
    end

    // FSM control decode.
    always_comb begin
        strobe_s      = next_pixel && !resync;
        issue_s       = 1'b0;
        decr_s        = 1'b0;
        capture_s     = 1'b0;
        consume_s     = 1'b0;
        underrun_ev_s = 1'b0;
        case (state_r)
            ISSUE: begin
                issue_s       = !resync && !next_pixel;
                underrun_ev_s = strobe_s;
            end
            WAIT: begin
                decr_s        = !resync && !next_pixel && (lat_r != 2'd0);
                capture_s     = !resync && !next_pixel && (lat_r == 2'd0);
                underrun_ev_s = strobe_s;
            end
            READY: begin
                consume_s = strobe_s;
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Linear buffer address of the current source pixel.
    always_comb begin
        addr_s = ADDR_W'(sy_s) * SRC_COLS_A + ADDR_W'(sx_s);
    end

    // Fetch datapath and registered outputs.
    always_ff @(posedge oclk) begin
        if (rst) begin
            fb_addr_r    <= '0;
            lat_r        <= 2'd0;
            pend_r       <= '0;
            color_r      <= 16'd0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            frame_done_r <= consume_s && last_pixel_s && !xy_mismatch_s;
            if (issue_s) begin
                fb_addr_r <= addr_s;
                lat_r     <= RD_LAT_C;
            end else if (decr_s) begin
                lat_r <= lat_r - 2'd1;
            end
            if (capture_s) begin
                pend_r <= fb_pxl;
            end
            if (consume_s) begin
                color_r <= rgb_buf_to_565(pend_r);
            end
            if (underrun_ev_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign fb_addr    = fb_addr_r;
    assign color      = color_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_oled_fb_reader.sv
// Scoreboard bench for oled_fb_reader: random-gap strobes over a full frame plus wrap, underrun, resync and reset cases.
module tb_oled_fb_reader;

    localparam int RD_LAT = 3;
    localparam int NPIX   = 320 * 240;

    logic        oclk = 1'b0;
    logic        rst = 1'b1;
    logic        next_pixel = 1'b0;
    logic        resync = 1'b0;
    logic [16:0] fb_addr;
    logic [15:0] fb_pxl;
    logic [15:0] color;
    logic        frame_done;
    logic        underrun;

    always #5 oclk = ~oclk;

    typedef struct {
        bit          chk_addr;
        int          addr;
        logic [15:0] color;
        bit          fd;
        bit          ur;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          px = 0, py = 0, cur_x = 0, cur_y = 0;
    logic [15:0] cur_color = 16'd0;
    bit          ur_exp = 1'b0;
    logic [15:0] mem [0:NPIX-1];
    logic [15:0] pipe [0:RD_LAT-1];

`ifdef OLED_FB_READER_XY_CHECK_EN
    logic [6:0] x, y;
    logic       xy_err;
    assign x = 7'(cur_x);
    assign y = 7'(cur_y);
`endif

    oled_fb_reader #(.RD_LAT(RD_LAT)) dut (
        .oclk       (oclk),
        .rst        (rst),
        .next_pixel (next_pixel),
        .resync     (resync),
        .fb_addr    (fb_addr),
        .fb_pxl     (fb_pxl),
        .color      (color),
        .frame_done (frame_done),
`ifdef OLED_FB_READER_XY_CHECK_EN
        .x          (x),
        .y          (y),
        .xy_err     (xy_err),
`endif
        .underrun   (underrun)
    );

    // Frame buffer read port with RD_LAT cycles of latency.
    always @(posedge oclk) begin
        pipe[0] <= mem[fb_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fb_pxl = pipe[RD_LAT-1];

    function automatic logic [15:0] conv(input logic [15:0] p);
        int r, g, b;
        r = p / 2048;
        g = (p / 64) % 32;
        b = p % 64;
        return 16'(r * 2048 + (g * 2 + g / 16) * 32 + b / 2);
    endfunction

    function automatic int ref_addr(input int cx, input int cy);
        int sx, sy;
        sx = (cx * 853) / 256;
        sy = (cy * 960) / 256;
        if (sx > 319) sx = 319;
        if (sy > 239) sy = 239;
        return sy * 320 + sx;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_model();
        cur_x = px;
        cur_y = py;
        px++;
        if (px == 96) begin
            px = 0;
            py = (py == 63) ? 0 : py + 1;
        end
    endtask

    task automatic push_consume();
        exp_t it;
        it.chk_addr = 1'b1;
        it.addr     = ref_addr(px, py);
        cur_color   = conv(mem[it.addr]);
        it.color    = cur_color;
        it.fd       = (px == 95) && (py == 63);
        it.ur       = ur_exp;
        sb.push_back(it);
        step_model();
    endtask

    task automatic pulse(input bit rs);
        @(posedge oclk); #1;
        next_pixel = 1'b1;
        resync     = rs;
        @(posedge oclk); #1;
        next_pixel = 1'b0;
        resync     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge oclk);
    endtask

    task automatic consume();
        push_consume();
        pulse(1'b0);
        idle($urandom_range(4, 7));
    endtask

    // Monitor: after every strobe, pop one expectation and compare; otherwise frame_done must be low.
    initial begin
        bit   prev_strobe;
        int   prev_addr;
        exp_t it;
        prev_strobe = 1'b0;
        prev_addr   = 0;
        forever begin
            @(negedge oclk);
            if (rst) begin
                prev_strobe = 1'b0;
            end else begin
                if (prev_strobe) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        if (it.chk_addr) chk("fb_addr", prev_addr, it.addr);
                        chk("color", int'(color), int'(it.color));
                        chk("frame_done", int'(frame_done), int'(it.fd));
                        chk("underrun", int'(underrun), int'(it.ur));
                    end
                end else begin
                    chk("frame_done_idle", int'(frame_done), 0);
                end
                prev_strobe = next_pixel || resync;
                prev_addr   = int'(fb_addr);
            end
        end
    end

    initial begin
        exp_t it;
        for (int a = 0; a < NPIX; a++) mem[a] = (a < 320) ? 16'(a) : 16'($urandom);
        mem[3] = 16'hFFFF;
        mem[6] = {5'd16, 5'd16, 6'd32};

        idle(3);
        @(negedge oclk);
        chk("rst_color", int'(color), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        @(posedge oclk); #1;
        rst = 1'b0;
        idle(8);

        // One full frame plus the first pixels of the next.
        for (int i = 0; i < 96 * 64 + 10; i++) consume();

        // Two back-to-back strobes: the second finds no prefetch.
        push_consume();
        @(posedge oclk); #1;
        next_pixel = 1'b1;
        @(posedge oclk); #1;
        it.chk_addr = 1'b0;
        it.addr     = 0;
        it.color    = cur_color;
        it.fd       = 1'b0;
        it.ur       = 1'b1;
        ur_exp      = 1'b1;
        sb.push_back(it);
        step_model();
        @(posedge oclk); #1;
        next_pixel = 1'b0;
        idle(6);
        for (int i = 0; i < 4; i++) consume();

        // resync together with next_pixel mid-frame.
        it.chk_addr = 1'b1;
        it.addr     = ref_addr(px, py);
        it.color    = cur_color;
        it.fd       = 1'b0;
        it.ur       = ur_exp;
        sb.push_back(it);
        cur_x = px;
        cur_y = py;
        px = 0;
        py = 0;
        pulse(1'b1);
        cur_x = 0;
        cur_y = 0;
        idle(6);
        for (int i = 0; i < 4; i++) consume();

        // Reset while a fetch is in flight.
        push_consume();
        pulse(1'b0);
        @(posedge oclk); #1;
        rst = 1'b1;
        @(posedge oclk); #1;
        chk("midrst_color", int'(color), 0);
        chk("midrst_fb_addr", int'(fb_addr), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        chk("midrst_underrun", int'(underrun), 0);
        rst       = 1'b0;
        px        = 0;
        py        = 0;
        cur_x     = 0;
        cur_y     = 0;
        cur_color = 16'd0;
        ur_exp    = 1'b0;
        idle(8);
        for (int i = 0; i < 3; i++) consume();

        idle(4);
        chk("sb_drained", sb.size(), 0);
`ifdef OLED_FB_READER_XY_CHECK_EN
        chk("xy_err", int'(xy_err), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
